// File: rtl/alu_cmd_sequencer.sv
// Byte-stream front end for the ALU: assembles 6-byte command frames into opcode/operand
// words, waits a fixed number of cycles, then returns the 16-bit ALU result as two bytes.
module alu_cmd_sequencer #(
    parameter int         WAIT_CYCLES = 3,
    parameter logic [6:0] HEADER      = 7'h55
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [7:0]  OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [8:0]  ALU_OPCODES,
    output logic [31:0] ALU_OPRANDS,
    input  logic [15:0] ALU_OUT,
    output logic        BUSY,
    output logic [7:0]  ERR_COUNT
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RX    = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_TX_HI = 3'd3;
    localparam logic [2:0] S_TX_LO = 3'd4;

    logic [2:0]  state;
    logic [2:0]  idx;
    logic [31:0] stage;
    logic        op_msb;
    logic [3:0]  count;
    logic [15:0] result;
    logic        in_fire;
    logic        out_fire;

    // IN_READY is held low while reset is asserted even though the state is already IDLE
    assign IN_READY  = !RST && ((state == S_IDLE) || (state == S_RX));
    assign OUT_VALID = (state == S_TX_HI) || (state == S_TX_LO);
    assign BUSY      = (state != S_IDLE);
    assign in_fire   = IN_VALID && IN_READY;
    assign out_fire  = OUT_VALID && OUT_READY;

    always_comb begin
        OUT_DATA = 8'h00;
        if (state == S_TX_HI) begin
            OUT_DATA = result[15:8];
        end else if (state == S_TX_LO) begin
            OUT_DATA = result[7:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            idx         <= 3'd0;
            stage       <= 32'h0;
            op_msb      <= 1'b0;
            count       <= 4'd0;
            result      <= 16'h0;
            ALU_OPCODES <= 9'h0;
            ALU_OPRANDS <= 32'h0;
            ERR_COUNT   <= 8'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_fire) begin
                        if (IN_DATA[7:1] == HEADER) begin
                            op_msb <= IN_DATA[0];
                            idx    <= 3'd1;
                            state  <= S_RX;
                        end else if (ERR_COUNT != 8'hFF) begin
                            ERR_COUNT <= ERR_COUNT + 8'd1;
                        end
                    end
                end
                S_RX: begin
                    // stage holds b1..b4 in order; b5 bypasses it straight onto the ALU operand
                    if (in_fire) begin
                        if (idx == 3'd5) begin
                            ALU_OPCODES <= {op_msb, stage[31:24]};
                            ALU_OPRANDS <= {stage[23:0], IN_DATA};
                            count       <= 4'(WAIT_CYCLES);
                            idx         <= 3'd0;
                            state       <= S_WAIT;
                        end else begin
                            stage <= {stage[23:0], IN_DATA};
                            idx   <= idx + 3'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (count == 4'd1) begin
                        result <= ALU_OUT;
                        state  <= S_TX_HI;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                S_TX_HI: begin
                    if (out_fire) begin
                        state <= S_TX_LO;
                    end
                end
                S_TX_LO: begin
                    if (out_fire) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed plan plus randomized frames,
// with a behavioural ALU and a frame-level reference model.
module tb_alu_cmd_sequencer;

    localparam int         WAIT_CYCLES = 3;
    localparam logic [6:0] HEADER      = 7'h55;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  inData;
    logic        inValid;
    logic        inReady;
    logic [7:0]  outData;
    logic        outValid;
    logic        outReady;
    logic [8:0]  aluOpcodes;
    logic [31:0] aluOprands;
    logic [15:0] aluOut;
    logic        busy;
    logic [7:0]  errCount;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    int          expErr = 0;
    logic [8:0]  expOpc = 9'h0;
    logic [31:0] expOpr = 32'h0;

    alu_cmd_sequencer #(.WAIT_CYCLES(WAIT_CYCLES), .HEADER(HEADER)) dut (
        .CLK(clock), .RST(reset),
        .IN_DATA(inData), .IN_VALID(inValid), .IN_READY(inReady),
        .OUT_DATA(outData), .OUT_VALID(outValid), .OUT_READY(outReady),
        .ALU_OPCODES(aluOpcodes), .ALU_OPRANDS(aluOprands), .ALU_OUT(aluOut),
        .BUSY(busy), .ERR_COUNT(errCount)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    // Behavioural ALU: three 3-bit op fields, two on operand byte pairs, one combining them
    function automatic logic [15:0] aluOp(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a * b;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return a ^ b;
            3'd6: return a;
            default: return b;
        endcase
    endfunction

    function automatic logic [15:0] aluModel(input logic [8:0] opc, input logic [31:0] opr);
        logic [15:0] s1;
        logic [15:0] s2;
        s1 = aluOp(opc[2:0], {8'h0, opr[31:24]}, {8'h0, opr[23:16]});
        s2 = aluOp(opc[5:3], {8'h0, opr[15:8]}, {8'h0, opr[7:0]});
        return aluOp(opc[8:6], s1, s2);
    endfunction

    always_comb aluOut = aluModel(aluOpcodes, aluOprands);

    function automatic logic [7:0] badByte();
        logic [7:0] b;
        b = 8'($urandom);
        if (b[7:1] == HEADER) b[1] = ~b[1];
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge
    task automatic sendByte(input logic [7:0] b, output int acceptCycle);
        bit accepted;
        accepted = 0;
        inData   = b;
        inValid  = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            if (inReady) accepted = 1;
            @(negedge clock);
        end
        inValid     = 1'b0;
        acceptCycle = cycle;
        if (!accepted) checkOutput("in_accept_timeout", 0, 1);
    endtask

    task automatic sendBad(input logic [7:0] b);
        int unused;
        sendByte(b, unused);
        expErr = (expErr >= 255) ? 255 : expErr + 1;
    endtask

    task automatic applyStimulus(input logic [8:0] opc, input logic [31:0] opr,
                                 input int badBytes, input int stall, input string name);
        logic [7:0]  frame [6];
        logic [15:0] expRes;
        int          acceptCycle;
        int          lat;
        frame[0] = {HEADER, opc[8]};
        frame[1] = opc[7:0];
        frame[2] = opr[31:24];
        frame[3] = opr[23:16];
        frame[4] = opr[15:8];
        frame[5] = opr[7:0];
        for (int i = 0; i < badBytes; i++) sendBad(badByte());
        if (badBytes > 0) checkOutput({name, "_err"}, 64'(errCount), 64'(expErr));
        for (int i = 0; i < 6; i++) sendByte(frame[i], acceptCycle);

        // Latency counts the b5 accept edge itself through the edge raising OUT_VALID
        lat = -1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            if (outValid) lat = cycle - acceptCycle + 1;
            else @(negedge clock);
        end
        checkOutput({name, "_latency"}, 64'(lat), 64'(WAIT_CYCLES + 1));

        expOpc = opc;
        expOpr = opr;
        expRes = aluModel(opc, opr);
        checkOutput({name, "_opcodes"}, 64'(aluOpcodes), 64'(expOpc));
        checkOutput({name, "_oprands"}, 64'(aluOprands), 64'(expOpr));

        for (int s = 0; s < stall; s++) begin
            checkOutput({name, "_stall_data"}, 64'(outData), 64'(expRes[15:8]));
            checkOutput({name, "_stall_valid"}, 64'(outValid), 64'(1));
            checkOutput({name, "_stall_inready"}, 64'(inReady), 64'(0));
            checkOutput({name, "_stall_busy"}, 64'(busy), 64'(1));
            @(negedge clock);
        end
        checkOutput({name, "_hi"}, 64'(outData), 64'(expRes[15:8]));
        outReady = 1'b1;
        @(negedge clock);
        checkOutput({name, "_lo_valid"}, 64'(outValid), 64'(1));
        checkOutput({name, "_lo"}, 64'(outData), 64'(expRes[7:0]));
        @(negedge clock);
        outReady = 1'b0;
        checkOutput({name, "_idle_busy"}, 64'(busy), 64'(0));
        checkOutput({name, "_idle_valid"}, 64'(outValid), 64'(0));
        checkOutput({name, "_idle_inready"}, 64'(inReady), 64'(1));
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_inready"}, 64'(inReady), 64'(0));
        checkOutput({name, "_outvalid"}, 64'(outValid), 64'(0));
        checkOutput({name, "_outdata"}, 64'(outData), 64'(0));
        checkOutput({name, "_busy"}, 64'(busy), 64'(0));
        checkOutput({name, "_err"}, 64'(errCount), 64'(0));
        checkOutput({name, "_opcodes"}, 64'(aluOpcodes), 64'(0));
        checkOutput({name, "_oprands"}, 64'(aluOprands), 64'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ac;
        reset    = 1'b1;
        inData   = 8'h00;
        inValid  = 1'b0;
        outReady = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkResetOutputs("reset");
        #2 reset = 1'b0;
        @(negedge clock);

        applyStimulus(9'h000, 32'h03040506, 0, 0, "add");
        checkOutput("add_result", 64'(aluModel(9'h000, 32'h03040506)), 64'h0012);
        applyStimulus(9'h092, 32'h0A0B0203, 0, 0, "mul");
        checkOutput("mul_result", 64'(aluModel(9'h092, 32'h0A0B0203)), 64'h0294);

        sendBad(8'h12);
        checkOutput("badhdr_err", 64'(errCount), 64'(1));
        checkOutput("badhdr_busy", 64'(busy), 64'(0));
        applyStimulus(9'h000, 32'h03040506, 0, 0, "badhdr_frame");

        applyStimulus(9'h092, 32'h0A0B0203, 0, 5, "backpressure");

        sendByte(8'hAA, ac);
        sendByte(8'h00, ac);
        sendByte(8'h03, ac);
        checkOutput("midrx_busy", 64'(busy), 64'(1));
        #2 reset = 1'b1;
        #1 checkResetOutputs("midrx_reset");
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        expErr = 0;
        expOpc = 9'h0;
        expOpr = 32'h0;
        applyStimulus(9'h092, 32'h0A0B0203, 0, 0, "after_reset");

        for (int n = 0; n < 20; n++) begin
            applyStimulus(9'($urandom), $urandom, int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 3)), "random");
        end

        for (int i = 0; i < 300; i++) sendBad(badByte());
        checkOutput("sat_err", 64'(errCount), 64'(expErr));
        checkOutput("sat_err_255", 64'(errCount), 64'(255));
        checkOutput("sat_busy", 64'(busy), 64'(0));
        checkOutput("sat_opcodes", 64'(aluOpcodes), 64'(expOpc));
        checkOutput("sat_oprands", 64'(aluOprands), 64'(expOpr));
        applyStimulus(9'($urandom), $urandom, 1, 1, "post_sat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
